// File: rtl/ysyx_icache_ifu_if.sv
// Fetch-side handshake and burst-read bus bundle for ysyx_icache_ifu.
// master = the IFU, slave = PC logic / IDU / memory side.
interface ysyx_icache_ifu_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_pc;
   logic              req_ready;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_inst;
   logic [ADDR_W-1:0] resp_pc;
   logic [ADDR_W-1:0] bus_araddr;
   logic              bus_arvalid;
   logic              bus_arready;
   logic [7:0]        bus_arlen;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_rvalid;
   logic              bus_rlast;

   modport master (
      input  req_valid, req_pc, resp_ready, bus_arready, bus_rdata, bus_rvalid, bus_rlast,
      output req_ready, resp_valid, resp_inst, resp_pc, bus_araddr, bus_arvalid, bus_arlen
   );

   modport slave (
      output req_valid, req_pc, resp_ready, bus_arready, bus_rdata, bus_rvalid, bus_rlast,
      input  req_ready, resp_valid, resp_inst, resp_pc, bus_araddr, bus_arvalid, bus_arlen
   );
endinterface

// File: rtl/ysyx_icache_ifu.sv
// Instruction fetch unit with a direct-mapped L1 I-cache and single-burst line refill.
// Define YSYX_ICACHE_PERF_EN to build the hit/miss performance counters.
module ysyx_icache_ifu #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SETS       = 16,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   ysyx_icache_ifu_if.master   ifu,
   output logic [31:0]         perf_hit,
   output logic [31:0]         perf_miss
);
   localparam int unsigned OFF_W = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W - 2;

   typedef enum logic [2:0] {StIdle, StLookup, StRefillAr, StRefillR, StResp} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q;
   logic [DATA_W-1:0]   resp_inst_q;
   logic [OFF_W-1:0]    beat_q;
   logic [SETS-1:0]     valid_q;
   logic                flushed_q;
   logic [TAG_W-1:0]    tag_q  [SETS];
   logic [DATA_W-1:0]   data_q [SETS*LINE_WORDS];

   logic [IDX_W-1:0]    idx;
   logic [OFF_W-1:0]    off;
   logic [TAG_W-1:0]    pc_tag;
   logic                hit;
   logic                last_beat;
   logic                beat_fire;

   assign idx       = pc_q[IDX_W+OFF_W+1:OFF_W+2];
   assign off       = pc_q[OFF_W+1:2];
   assign pc_tag    = pc_q[ADDR_W-1:ADDR_W-TAG_W];
   assign hit       = valid_q[idx] && (tag_q[idx] == pc_tag);
   assign last_beat = (beat_q == OFF_W'(LINE_WORDS - 1));
   assign beat_fire = (state_q == StRefillR) && ifu.bus_rvalid;

   always_comb begin
      state_d         = state_q;
      ifu.req_ready   = 1'b0;
      ifu.resp_valid  = 1'b0;
      ifu.bus_arvalid = 1'b0;
      unique case (state_q)
         StIdle: begin
            ifu.req_ready = 1'b1;
            if (ifu.req_valid) state_d = StLookup;
         end
         StLookup:   state_d = hit ? StResp : StRefillAr;
         StRefillAr: begin
            ifu.bus_arvalid = 1'b1;
            if (ifu.bus_arready) state_d = StRefillR;
         end
         StRefillR:  if (beat_fire && last_beat) state_d = StResp;
         StResp: begin
            ifu.resp_valid = 1'b1;
            if (ifu.resp_ready) state_d = StIdle;
         end
         default:    state_d = StIdle;
      endcase
   end

   assign ifu.resp_inst  = resp_inst_q;
   assign ifu.resp_pc    = pc_q;
   assign ifu.bus_araddr = {pc_q[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
   assign ifu.bus_arlen  = 8'(LINE_WORDS - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         resp_inst_q <= '0;
         beat_q      <= '0;
         valid_q     <= '0;
         flushed_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && ifu.req_valid) pc_q <= ifu.req_pc;
         if (state_q == StLookup && hit) resp_inst_q <= data_q[{idx, off}];
         if (state_q == StRefillAr) begin
            beat_q    <= '0;
            flushed_q <= 1'b0;
         end
         if (state_q == StRefillR && flush) flushed_q <= 1'b1;
         if (beat_fire) begin
            beat_q <= beat_q + OFF_W'(1);
            if (beat_q == off) resp_inst_q <= ifu.bus_rdata;
         end
         // A flush seen anywhere in the burst means the line may hold stale words.
         if (flush) begin
            valid_q <= '0;
         end else if (beat_fire && last_beat && !flushed_q) begin
            valid_q[idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && beat_fire) begin
         data_q[{idx, beat_q}] <= ifu.bus_rdata;
         if (last_beat) tag_q[idx] <= pc_tag;
      end
   end

`ifdef YSYX_ICACHE_PERF_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == StLookup) begin
         if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
         else     miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign perf_hit  = hit_cnt_q;
   assign perf_miss = miss_cnt_q;
`else
   assign perf_hit  = '0;
   assign perf_miss = '0;
`endif

   // Sequencing counts beats itself, so rlast and the byte offset are never consulted.
   logic unused_sig;
   assign unused_sig = ^{pc_q[1:0], ifu.bus_rlast};
endmodule

// File: tb/tb_ysyx_icache_ifu.sv
// Bench for ysyx_icache_ifu: directed vector table plus randomized fetches against a cache model.
module tb_ysyx_icache_ifu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] perf_hit, perf_miss;

   ysyx_icache_ifu_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

   ysyx_icache_ifu #(.ADDR_W(32), .DATA_W(32), .SETS(16), .LINE_WORDS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ifu       (bus_if),
      .perf_hit  (perf_hit),
      .perf_miss (perf_miss)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: per-set valid/tag; line index = pc[7:4], tag = pc[31:8].
   bit          mv [16];
   logic [23:0] mt [16];
   int          m_hit  = 0;
   int          m_miss = 0;

   typedef struct {
      logic [31:0] pc;
      int          ar_delay;
      int          resp_delay;
      int          flush_beat;
      bit          flush_before;
      bit          exp_miss;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:4] == 28'h8000000) return 32'h11 * (32'(a[3:2]) + 32'd1);
      return a ^ 32'h5A5A_1234;
   endfunction

   function automatic bit model_miss(input logic [31:0] pc);
      return !mv[pc[7:4]] || (mt[pc[7:4]] != pc[31:8]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
   endtask

   task automatic check_perf(input string name);
`ifdef YSYX_ICACHE_PERF_EN
      check({name, "_perf_hit"}, perf_hit, 32'(m_hit));
      check({name, "_perf_miss"}, perf_miss, 32'(m_miss));
`else
      check({name, "_perf_hit"}, perf_hit, 32'd0);
      check({name, "_perf_miss"}, perf_miss, 32'd0);
`endif
   endtask

   task automatic idle_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("idle_flush_req_ready", 32'(bus_if.req_ready), 32'd1);
      model_clear();
   endtask

   task automatic fetch(input logic [31:0] pc, input int ar_delay, input int resp_delay,
                        input int flush_beat, input bit exp_miss, input logic [31:0] exp_inst);
      logic [31:0] line;
      int          gap;
      line = {pc[31:4], 4'h0};
      check("accept_req_ready", 32'(bus_if.req_ready), 32'd1);
      bus_if.req_valid = 1'b1;
      bus_if.req_pc    = pc;
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      bus_if.req_pc    = $urandom;
      check("lookup_resp_valid", 32'(bus_if.resp_valid), 32'd0);
      check("lookup_req_ready", 32'(bus_if.req_ready), 32'd0);
      @(negedge clk);
      if (exp_miss) begin
         m_miss++;
         check("miss_arvalid", 32'(bus_if.bus_arvalid), 32'd1);
         check("miss_araddr", bus_if.bus_araddr, line);
         check("miss_arlen", 32'(bus_if.bus_arlen), 32'd3);
         for (int d = 0; d < ar_delay; d++) begin
            @(negedge clk);
            check("ar_wait_arvalid", 32'(bus_if.bus_arvalid), 32'd1);
            check("ar_wait_araddr", bus_if.bus_araddr, line);
            check("ar_wait_req_ready", 32'(bus_if.req_ready), 32'd0);
         end
         bus_if.bus_arready = 1'b1;
         @(negedge clk);
         bus_if.bus_arready = 1'b0;
         check("after_ar_arvalid", 32'(bus_if.bus_arvalid), 32'd0);
         for (int b = 0; b < 4; b++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) @(negedge clk);
            bus_if.bus_rvalid = 1'b1;
            bus_if.bus_rdata  = mem_word(line + 32'(b * 4));
            bus_if.bus_rlast  = (b == 3) ? 1'b1 : ($urandom_range(0, 3) == 0);
            flush             = (b == flush_beat);
            @(negedge clk);
            bus_if.bus_rvalid = 1'b0;
            bus_if.bus_rlast  = 1'b0;
            bus_if.bus_rdata  = $urandom;
            flush             = 1'b0;
         end
         if (flush_beat >= 0 && flush_beat < 4) begin
            model_clear();
         end else begin
            mv[pc[7:4]] = 1'b1;
            mt[pc[7:4]] = pc[31:8];
         end
      end else begin
         m_hit++;
         check("hit_arvalid", 32'(bus_if.bus_arvalid), 32'd0);
      end
      check("resp_valid", 32'(bus_if.resp_valid), 32'd1);
      check("resp_inst", bus_if.resp_inst, exp_inst);
      check("resp_pc", bus_if.resp_pc, pc);
      check("resp_req_ready", 32'(bus_if.req_ready), 32'd0);
      for (int d = 0; d < resp_delay; d++) begin
         @(negedge clk);
         check("hold_resp_valid", 32'(bus_if.resp_valid), 32'd1);
         check("hold_resp_inst", bus_if.resp_inst, exp_inst);
         check("hold_resp_pc", bus_if.resp_pc, pc);
         check("hold_req_ready", 32'(bus_if.req_ready), 32'd0);
      end
      bus_if.resp_ready = 1'b1;
      @(negedge clk);
      bus_if.resp_ready = 1'b0;
      check("done_resp_valid", 32'(bus_if.resp_valid), 32'd0);
      check("done_req_ready", 32'(bus_if.req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] pc;
      int          fb;
      bus_if.req_valid   = 1'b0;
      bus_if.req_pc      = '0;
      bus_if.resp_ready  = 1'b0;
      bus_if.bus_arready = 1'b0;
      bus_if.bus_rdata   = '0;
      bus_if.bus_rvalid  = 1'b0;
      bus_if.bus_rlast   = 1'b0;
      model_clear();

      //          pc            ard rsd  fb  fbefore miss inst
      vecs[0]  = '{32'h8000_0008, 0, 0, -1, 1'b0, 1'b1, 32'h0000_0033};
      vecs[1]  = '{32'h8000_000C, 0, 0, -1, 1'b0, 1'b0, 32'h0000_0044};
      vecs[2]  = '{32'h8000_0100, 1, 0, -1, 1'b0, 1'b1, 32'hDA5A_1334};
      vecs[3]  = '{32'h8000_0000, 3, 5, -1, 1'b0, 1'b1, 32'h0000_0011};
      vecs[4]  = '{32'h8000_0004, 0, 1, -1, 1'b0, 1'b0, 32'h0000_0022};
      vecs[5]  = '{32'h8000_0010, 0, 0,  2, 1'b0, 1'b1, 32'hDA5A_1224};
      vecs[6]  = '{32'h8000_0010, 0, 0, -1, 1'b0, 1'b1, 32'hDA5A_1224};
      vecs[7]  = '{32'h8000_0014, 0, 0, -1, 1'b0, 1'b0, 32'hDA5A_1220};
      vecs[8]  = '{32'h8000_0000, 0, 0,  3, 1'b0, 1'b1, 32'h0000_0011};
      vecs[9]  = '{32'h8000_0004, 0, 0, -1, 1'b0, 1'b1, 32'h0000_0022};
      vecs[10] = '{32'h8000_0008, 0, 0, -1, 1'b1, 1'b1, 32'h0000_0033};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
      check("rst_arvalid", 32'(bus_if.bus_arvalid), 32'd0);
      check("rst_resp_inst", bus_if.resp_inst, 32'd0);
      check("rst_resp_pc", bus_if.resp_pc, 32'd0);
      check_perf("rst");

      foreach (vecs[i]) begin
         if (vecs[i].flush_before) idle_flush();
         fetch(vecs[i].pc, vecs[i].ar_delay, vecs[i].resp_delay, vecs[i].flush_beat,
               vecs[i].exp_miss, vecs[i].exp_inst);
      end
      check_perf("table");

      for (int n = 0; n < 40; n++) begin
         pc = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
         if ($urandom_range(0, 9) == 0) idle_flush();
         fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
         fetch(pc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), fb, model_miss(pc),
               mem_word(pc));
      end
      check_perf("random");

      // Reset in the middle of a burst; later beats must be dropped.
      fetch(32'h8000_0000, 0, 0, -1, model_miss(32'h8000_0000), 32'h0000_0011);
      bus_if.req_valid = 1'b1;
      bus_if.req_pc    = 32'h8000_0024;
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      @(negedge clk);
      bus_if.bus_arready = 1'b1;
      @(negedge clk);
      bus_if.bus_arready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus_if.bus_rvalid = 1'b1;
         bus_if.bus_rdata  = 32'hBAD0_0000 + 32'(b);
         bus_if.bus_rlast  = (b == 3);
         rst               = (b == 2);
         @(negedge clk);
      end
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rlast  = 1'b0;
      rst = 1'b0;
      model_clear();
      m_hit  = 0;
      m_miss = 0;
      check("midrst_req_ready", 32'(bus_if.req_ready), 32'd1);
      check("midrst_arvalid", 32'(bus_if.bus_arvalid), 32'd0);
      check("midrst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
      check("midrst_resp_inst", bus_if.resp_inst, 32'd0);
      check("midrst_resp_pc", bus_if.resp_pc, 32'd0);
      check_perf("midrst");
      fetch(32'h8000_0000, 0, 0, -1, 1'b1, 32'h0000_0011);
      fetch(32'h8000_0004, 0, 0, -1, 1'b0, 32'h0000_0022);
      check_perf("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no end of test required finish");
      $fatal(1);
   end
endmodule
